// File: rtl/mem_resp_pkg.sv
// Shared types and defaults for the memory responder.
package mem_resp_pkg;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned LAT_W      = 4;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

endpackage

// File: rtl/mem_resp_array.sv
// Single-port word storage with registered read; contents are never reset.
module mem_resp_array #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 256,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[addr] <= wdata;
    end
    r_rdata <= r_mem[addr];
  end

  assign rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: acks master cycles after LATENCY wait states.
// Define MEM_RESP_RANGE_CHECK_EN to answer out-of-range addresses with err_mem instead of ack_mem.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cyc_m2s,
  input  logic              we_m2s,
  input  logic [ADDR_W-1:0] adr_m2s,
  input  logic [DATA_W-1:0] dat_m2s,
  output logic              ack_mem,
  output logic [DATA_W-1:0] dat_mem,
  output logic              err_mem,
  output logic              busy
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  state_e            r_state, w_state_d;
  logic [LAT_W-1:0]  r_cnt, w_cnt_d;
  logic              r_we;
  logic [ADDR_W-1:0] r_adr;
  logic [DATA_W-1:0] r_wdat;
  logic [DATA_W-1:0] r_dat_out;
  logic              r_ack;

  logic              w_start;
  logic              w_enter_resp;
  logic              w_cur_we;
  logic [ADDR_W-1:0] w_cur_adr;
  logic [DATA_W-1:0] w_cur_dat;
  logic              w_in_range;
  logic              w_mem_we;
  logic [IDX_W-1:0]  w_idx;
  logic [DATA_W-1:0] w_rdata;

  // In IDLE the live bus is the request (LATENCY=0 completes on the sampling edge).
  always_comb begin
    w_start   = (r_state == StIdle) && cyc_m2s;
    w_cur_we  = (r_state == StIdle) ? we_m2s  : r_we;
    w_cur_adr = (r_state == StIdle) ? adr_m2s : r_adr;
    w_cur_dat = (r_state == StIdle) ? dat_m2s : r_wdat;
    w_idx     = IDX_W'(w_cur_adr);
  end

`ifdef MEM_RESP_RANGE_CHECK_EN
  assign w_in_range = ({1'b0, w_cur_adr} < (ADDR_W + 1)'(DEPTH));
`else
  assign w_in_range = 1'b1;
`endif

  always_comb begin
    w_state_d    = r_state;
    w_cnt_d      = r_cnt;
    w_enter_resp = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (cyc_m2s) begin
          if (LATENCY == 0) begin
            w_state_d    = StResp;
            w_enter_resp = 1'b1;
          end else begin
            w_state_d = StWait;
            w_cnt_d   = LAT_W'(LATENCY);
          end
        end
      end
      StWait: begin
        if (!cyc_m2s) begin
          w_state_d = StIdle;
          w_cnt_d   = '0;
        end else if (r_cnt == LAT_W'(1)) begin
          w_state_d    = StResp;
          w_enter_resp = 1'b1;
          w_cnt_d      = '0;
        end else begin
          w_cnt_d = r_cnt - LAT_W'(1);
        end
      end
      StResp: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
        w_cnt_d   = '0;
      end
    endcase
  end

  // Storage is not reset, so gate its write enable while reset is held.
  assign w_mem_we = rst && w_enter_resp && w_cur_we && w_in_range;

  mem_resp_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (w_mem_we),
    .addr  (w_idx),
    .wdata (w_cur_dat),
    .rdata (w_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_we      <= 1'b0;
      r_adr     <= '0;
      r_wdat    <= '0;
      r_ack     <= 1'b0;
      r_dat_out <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      if (w_start) begin
        r_we   <= we_m2s;
        r_adr  <= adr_m2s;
        r_wdat <= dat_m2s;
      end
      r_ack <= w_enter_resp && w_in_range;
      if (r_ack && !r_we) begin
        r_dat_out <= w_rdata;
      end
    end
  end

`ifdef MEM_RESP_RANGE_CHECK_EN
  logic r_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_enter_resp && !w_in_range;
    end
  end

  assign err_mem = r_err;
`else
  assign err_mem = 1'b0;
`endif

  // The array read register holds fresh data only during the ack cycle.
  assign dat_mem = (r_ack && !r_we) ? w_rdata : r_dat_out;
  assign ack_mem = r_ack;
  assign busy    = (r_state != StIdle);

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (LATENCY 2, 0, 3; DEPTH 128), honours MEM_RESP_RANGE_CHECK_EN.
module tb_mem_responder;

`ifdef MEM_RESP_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        cyc  [3];
  logic        we   [3];
  logic [7:0]  adr  [3];
  logic [31:0] dat  [3];
  logic        ack  [3];
  logic        err  [3];
  logic        busy [3];
  logic [31:0] dmem [3];

  int          lat_tab [3] = '{2, 0, 3};
  logic [31:0] held_m  [3];

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic        err;
    logic [31:0] dat;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    int          k;
    logic        w;
    logic [7:0]  a;
    logic [31:0] d;
    logic        e_err;
    logic [31:0] e_rd;
  } vec_t;
  vec_t vecs [17];

  mem_responder #(.ADDR_W(8), .DATA_W(32), .DEPTH(128), .LATENCY(2)) u_dut_l2 (
    .clk(clk), .rst(rst), .cyc_m2s(cyc[0]), .we_m2s(we[0]), .adr_m2s(adr[0]),
    .dat_m2s(dat[0]), .ack_mem(ack[0]), .dat_mem(dmem[0]), .err_mem(err[0]), .busy(busy[0])
  );
  mem_responder #(.ADDR_W(8), .DATA_W(32), .DEPTH(128), .LATENCY(0)) u_dut_l0 (
    .clk(clk), .rst(rst), .cyc_m2s(cyc[1]), .we_m2s(we[1]), .adr_m2s(adr[1]),
    .dat_m2s(dat[1]), .ack_mem(ack[1]), .dat_mem(dmem[1]), .err_mem(err[1]), .busy(busy[1])
  );
  mem_responder #(.ADDR_W(8), .DATA_W(32), .DEPTH(128), .LATENCY(3)) u_dut_l3 (
    .clk(clk), .rst(rst), .cyc_m2s(cyc[2]), .we_m2s(we[2]), .adr_m2s(adr[2]),
    .dat_m2s(dat[2]), .ack_mem(ack[2]), .dat_mem(dmem[2]), .err_mem(err[2]), .busy(busy[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s (inst %0d): got %h expected %h", name, k, act, exp);
    end
  endtask

  // One full transaction; inputs are scrambled while waiting to prove they are latched.
  task automatic txn(input int k, input logic w, input logic [7:0] a, input logic [31:0] d,
                     input logic e_err, input logic [31:0] e_rd);
    exp_t ex;
    exp_t got;
    bit   done;
    ex.err = e_err;
    ex.dat = (!w && !e_err) ? e_rd : held_m[k];
    sb_q.push_back(ex);
    @(negedge clk);
    cyc[k] = 1'b1; we[k] = w; adr[k] = a; dat[k] = d;
    done = 1'b0;
    for (int n = 0; n < 32 && !done; n++) begin
      @(negedge clk);
      if (ack[k] || err[k]) begin
        done   = 1'b1;
        cyc[k] = 1'b0;
        check("sb_depth", k, sb_q.size(), 1);
        if (sb_q.size() > 0) begin
          got = sb_q.pop_front();
          check("ack_latency", k, n, lat_tab[k]);
          check("ack", k, ack[k], !got.err);
          check("err", k, err[k], got.err);
          check("dat_mem", k, dmem[k], got.dat);
          check("busy_resp", k, busy[k], 1);
          if (!w && !got.err) held_m[k] = got.dat;
        end
      end else begin
        check("busy_wait", k, busy[k], 1);
        we[k] = ~w; adr[k] = ~a; dat[k] = ~d;
      end
    end
    check("ack_timeout", k, done, 1);
    if (!done) begin
      cyc[k] = 1'b0;
      sb_q.delete();
    end
    @(negedge clk);
    check("ack_drop", k, ack[k], 0);
    check("err_drop", k, err[k], 0);
    check("busy_drop", k, busy[k], 0);
    check("dat_hold", k, dmem[k], held_m[k]);
  endtask

  initial begin
    exp_t got;

    vecs[0]  = '{0, 1'b1, 8'h10, 32'hDEADBEEF, 1'b0, 32'h0};
    vecs[1]  = '{0, 1'b0, 8'h10, 32'h0,        1'b0, 32'hDEADBEEF};
    vecs[2]  = '{0, 1'b1, 8'h7F, 32'h0BADF00D, 1'b0, 32'h0};
    vecs[3]  = '{0, 1'b0, 8'h7F, 32'h0,        1'b0, 32'h0BADF00D};
    vecs[4]  = '{0, 1'b1, 8'h90, 32'h00000055, RC,   32'h0};
    vecs[5]  = '{0, 1'b0, 8'h10, 32'h0,        1'b0, RC ? 32'hDEADBEEF : 32'h00000055};
    vecs[6]  = '{0, 1'b0, 8'h90, 32'h0,        RC,   32'h00000055};
    vecs[7]  = '{0, 1'b0, 8'h7F, 32'h0,        1'b0, 32'h0BADF00D};
    vecs[8]  = '{1, 1'b1, 8'h00, 32'hA0A00000, 1'b0, 32'h0};
    vecs[9]  = '{1, 1'b1, 8'h01, 32'hA0A00001, 1'b0, 32'h0};
    vecs[10] = '{1, 1'b1, 8'h02, 32'hA0A00002, 1'b0, 32'h0};
    vecs[11] = '{1, 1'b1, 8'h03, 32'hA0A00003, 1'b0, 32'h0};
    vecs[12] = '{1, 1'b0, 8'h02, 32'h0,        1'b0, 32'hA0A00002};
    vecs[13] = '{2, 1'b1, 8'h20, 32'h0000AAAA, 1'b0, 32'h0};
    vecs[14] = '{2, 1'b1, 8'h30, 32'h00003333, 1'b0, 32'h0};
    vecs[15] = '{2, 1'b0, 8'h30, 32'h0,        1'b0, 32'h00003333};
    vecs[16] = '{2, 1'b0, 8'h20, 32'h0,        1'b0, 32'h0000AAAA};

    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc[k] = 1'b0; we[k] = 1'b0; adr[k] = '0; dat[k] = '0; held_m[k] = '0;
    end

    // Reset then idle
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        check("rst_ack", k, ack[k], 0);
        check("rst_err", k, err[k], 0);
        check("rst_busy", k, busy[k], 0);
        check("rst_dat", k, dmem[k], 0);
      end
    end

    for (int i = 0; i < 17; i++) begin
      txn(vecs[i].k, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].e_err, vecs[i].e_rd);
    end

    // LATENCY=0 back-to-back reads with cyc held high
    sb_q.delete();
    @(negedge clk);
    cyc[1] = 1'b1; we[1] = 1'b0; adr[1] = 8'h00;
    sb_q.push_back('{1'b0, 32'hA0A00000});
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("b2b_ack", 1, ack[1], (i % 2 == 0) ? 1 : 0);
      if (ack[1] && sb_q.size() > 0) begin
        got = sb_q.pop_front();
        check("b2b_dat", 1, dmem[1], got.dat);
        held_m[1] = got.dat;
        if (i < 6) begin
          adr[1] = 8'(i / 2 + 1);
          sb_q.push_back('{1'b0, 32'hA0A00000 + 32'(i / 2 + 1)});
        end else begin
          cyc[1] = 1'b0;
        end
      end
    end
    check("b2b_sb_empty", 1, sb_q.size(), 0);
    cyc[1] = 1'b0;
    sb_q.delete();

    // Abort a read after one wait cycle
    @(negedge clk);
    cyc[2] = 1'b1; we[2] = 1'b0; adr[2] = 8'h30;
    @(negedge clk);
    check("abort_busy_wait", 2, busy[2], 1);
    check("abort_no_ack0", 2, ack[2], 0);
    cyc[2] = 1'b0;
    @(negedge clk);
    check("abort_busy_drop", 2, busy[2], 0);
    check("abort_dat_hold", 2, dmem[2], 32'h0000AAAA);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("abort_no_ack", 2, ack[2], 0);
      check("abort_no_err", 2, err[2], 0);
    end

    // Abort a write; storage must keep the old word
    @(negedge clk);
    cyc[2] = 1'b1; we[2] = 1'b1; adr[2] = 8'h30; dat[2] = 32'hDEAD0000;
    @(negedge clk);
    cyc[2] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("abortw_no_ack", 2, ack[2], 0);
    end
    txn(2, 1'b0, 8'h30, 32'h0, 1'b0, 32'h00003333);

    // Asynchronous reset in the middle of a write's wait phase
    @(negedge clk);
    cyc[2] = 1'b1; we[2] = 1'b1; adr[2] = 8'h20; dat[2] = 32'h0000BBBB;
    @(negedge clk);
    check("mid_busy", 2, busy[2], 1);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_busy", 2, busy[2], 0);
    check("mid_rst_ack", 2, ack[2], 0);
    check("mid_rst_dat", 2, dmem[2], 0);
    check("mid_rst_dat_other", 0, dmem[0], 0);
    cyc[2] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("mid_rst_no_ack", 2, ack[2], 0);
    end
    rst = 1'b1;
    for (int k = 0; k < 3; k++) held_m[k] = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("post_rst_no_ack", 2, ack[2], 0);
    end
    txn(2, 1'b0, 8'h20, 32'h0, 1'b0, 32'h0000AAAA);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
